mem_bus_master: RTL and testbench

Bus master that sits directly upstream of the 256×8 data memory. It accepts read/write requests from the CPU core over a valid/ready handshake and sequences them onto the memory's request lines and the shared bidirectional 8-bit `uniBus`. It returns read data, and a completion pulse for each access, to the core. One access is in flight at a time, and the memory's one-cycle recovery state is respected.

---
 rtl/mem_bus_master_if.sv | 30 +++
 rtl/mem_bus_master.sv | 142 ++++++++++++++
 tb/tb_mem_bus_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_master_if.sv
// Core request/response and memory strobe signals of the data-memory bus master.
// The shared bidirectional data bus stays a plain inout port on the master.
interface mem_bus_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_is_read;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_run;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;

    modport master (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_is_read, rsp_rdata,
        output mem_run, mem_rw, mem_addr
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_is_read, rsp_rdata,
        input  mem_run, mem_rw, mem_addr
    );
endinterface

// File: rtl/mem_bus_master.sv
// Bus master sequencing core requests onto the 256x8 data memory and its shared uniBus.
// Define MBM_REQ_FIFO_EN to place a FIFO_DEPTH-entry request queue in front of the FSM.
module mem_bus_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    mem_bus_master_if.master  bus,
    inout  wire  [DATA_W-1:0] uniBus
);
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        ACCESS  = 3'b010,
        RECOVER = 3'b100
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rsp_is_read;

    logic              w_avail;
    logic              w_slot_free;
    logic              w_load;
    logic              w_src_rw;
    logic [ADDR_W-1:0] w_src_addr;
    logic [DATA_W-1:0] w_src_wdata;

    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("mem_bus_master: FIFO_DEPTH must be at least 1");
    end

    // A new access may be loaded only outside ACCESS, which keeps mem_run off for a cycle between accesses.
    assign w_slot_free = (r_state == IDLE) || (r_state == RECOVER);
    assign w_load      = w_slot_free && w_avail;

`ifdef MBM_REQ_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

    logic              r_q_rw    [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_q_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_q_wdata [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;

    // Ready depends only on occupancy, so a full queue never passes a request through.
    assign bus.req_ready = (r_count < DEPTH_C);
    assign w_push        = bus.req_valid && bus.req_ready;
    assign w_avail       = (r_count != '0);
    assign w_src_rw      = r_q_rw[r_rptr];
    assign w_src_addr    = r_q_addr[r_rptr];
    assign w_src_wdata   = r_q_wdata[r_rptr];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == LAST_C) ? '0 : r_wptr + 1'b1;
            if (w_load) r_rptr <= (r_rptr == LAST_C) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_rw[r_wptr]    <= bus.req_rw;
            r_q_addr[r_wptr]  <= bus.req_addr;
            r_q_wdata[r_wptr] <= bus.req_wdata;
        end
    end
`else
    assign bus.req_ready = w_slot_free;
    assign w_avail       = bus.req_valid;
    assign w_src_rw      = bus.req_rw;
    assign w_src_addr    = bus.req_addr;
    assign w_src_wdata   = bus.req_wdata;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_avail) w_next = ACCESS;
            ACCESS:  w_next = RECOVER;
            RECOVER: w_next = w_avail ? ACCESS : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_mem_rw      <= 1'b1;
            r_mem_addr    <= '0;
            r_rdata       <= '0;
            r_rsp_is_read <= 1'b0;
        end else begin
            if (w_load) begin
                r_mem_rw   <= w_src_rw;
                r_mem_addr <= w_src_addr;
            end
            // Read data is on the bus for the whole ACCESS cycle; writes leave the last read value intact.
            if (r_state == ACCESS) begin
                r_rsp_is_read <= r_mem_rw;
                if (r_mem_rw) r_rdata <= uniBus;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_load) r_wdata <= w_src_wdata;
    end

    assign bus.mem_run     = (r_state == ACCESS);
    assign bus.mem_rw      = r_mem_rw;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.rsp_valid   = (r_state == RECOVER);
    assign bus.rsp_is_read = r_rsp_is_read;
    assign bus.rsp_rdata   = r_rdata;

    // State resets asynchronously, so the write driver drops off the bus as soon as RST falls.
    assign uniBus = ((r_state == ACCESS) && !r_mem_rw) ? r_wdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: directed requests push expected responses,
// negedge monitors check responses, bus ownership and mem_run cadence.
`timescale 1ns/1ps
module tb_mem_bus_master;
    localparam int         AW    = 8;
    localparam int         DW    = 8;
    localparam logic [7:0] PROBE = 8'h81;

    typedef struct {
        logic       is_read;
        logic [7:0] rdata;
        int         acc_cyc;
    } rsp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    wire  [7:0] uniBus;

    mem_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .bus    (bif),
        .uniBus (uniBus)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [256];
    logic       preload  = 1'b0;
    int         cyc      = 0;
    logic       prev_run = 1'b0;
    logic [7:0] exp_last = 8'h00;
    rsp_t       sb [$];
    logic [7:0] wq [$];
    int         n_vec  = 0;
    int         n_fail = 0;

    // Memory model: drives read data during a read strobe, otherwise the bench keeps a
    // recognisable probe pattern on the bus so any stray DUT drive corrupts it.
    assign uniBus = (bif.mem_run ? bif.mem_rw : 1'b1) ? (bif.mem_run ? mem[bif.mem_addr] : PROBE) : 8'bz;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (preload) begin
            mem[8'h10] <= 8'hA5;
            mem[8'h01] <= 8'h11;
            mem[8'h02] <= 8'h22;
            mem[8'h03] <= 8'h33;
            mem[8'h04] <= 8'h44;
        end else if (bif.mem_run && !bif.mem_rw) begin
            mem[bif.mem_addr] <= uniBus;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge CLK) begin : b_rsp_mon
        rsp_t e;
        if (bif.rsp_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=1, want no response pending (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("rsp_is_read", bif.rsp_is_read, e.is_read);
                check("rsp_rdata", bif.rsp_rdata, e.rdata);
`ifndef MBM_REQ_FIFO_EN
                check("rsp_latency", cyc, e.acc_cyc + 1);
`endif
            end
        end
    end

    always @(negedge CLK) begin : b_bus_mon
        check("mem_run_b2b", prev_run & bif.mem_run, 0);
        if (bif.mem_run && !bif.mem_rw) begin
            if (wq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL bus_wr_unexpected: got write strobe, want none (t=%0t)", $time);
            end else begin
                check("bus_wdata", uniBus, wq.pop_front());
            end
        end else if (!bif.mem_run) begin
            check("bus_released", uniBus, PROBE);
        end
        prev_run <= bif.mem_run;
    end

    task automatic issue(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rd, output int waits);
        rsp_t e;
        @(negedge CLK);
        bif.req_valid = 1'b1;
        bif.req_rw    = rw;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        waits = 0;
        while (!bif.req_ready && waits < 20) begin
            @(negedge CLK);
            waits++;
        end
        if (!bif.req_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, want accept", waits);
            bif.req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        bif.req_valid = 1'b0;
        if (rw) exp_last = exp_rd;
        e.is_read = rw;
        e.rdata   = exp_last;
        e.acc_cyc = cyc;
        sb.push_back(e);
        if (!rw) wq.push_back(wdata);
`ifndef MBM_REQ_FIFO_EN
        check("access_start", bif.mem_run, 1);
        check("mem_addr", bif.mem_addr, addr);
`endif
        // Disturb the request lines: an accepted request must already be registered.
        bif.req_rw    = ~rw;
        bif.req_addr  = ~addr;
        bif.req_wdata = ~wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int wsum;
        bif.req_valid = 1'b0;
        bif.req_rw    = 1'b1;
        bif.req_addr  = 8'h00;
        bif.req_wdata = 8'h00;
        preload = 1'b1;
        #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        preload = 1'b0;
        check("rst_req_ready", bif.req_ready, 1);
        check("rst_rsp_valid", bif.rsp_valid, 0);
        check("rst_rsp_is_read", bif.rsp_is_read, 0);
        check("rst_rsp_rdata", bif.rsp_rdata, 8'h00);
        check("rst_mem_run", bif.mem_run, 0);
        check("rst_mem_rw", bif.mem_rw, 1);
        check("rst_mem_addr", bif.mem_addr, 8'h00);
        @(negedge CLK);
        RST = 1'b1;

        repeat (5) begin
            @(negedge CLK);
            #1;
            check("idle_req_ready", bif.req_ready, 1);
            check("idle_rsp_valid", bif.rsp_valid, 0);
            check("idle_mem_run", bif.mem_run, 0);
        end

        issue(1'b1, 8'h10, 8'h00, 8'hA5, w);
        repeat (3) @(negedge CLK);
        issue(1'b0, 8'h20, 8'h3C, 8'h00, w);
        repeat (2) @(negedge CLK);
        issue(1'b1, 8'h20, 8'h00, 8'h3C, w);
        repeat (3) @(negedge CLK);

        issue(1'b0, 8'hFF, 8'hC7, 8'h00, w);
        issue(1'b1, 8'hFF, 8'h00, 8'hC7, w);
`ifndef MBM_REQ_FIFO_EN
        check("b2b_ready_low_in_access", w, 1);
`endif
        issue(1'b0, 8'h30, 8'h5A, 8'h00, w);
        issue(1'b1, 8'h30, 8'h00, 8'h5A, w);
`ifndef MBM_REQ_FIFO_EN
        check("b2b_ready_low_in_access2", w, 1);
`endif
        repeat (4) @(negedge CLK);

`ifdef MBM_REQ_FIFO_EN
        wsum = 0;
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    issue(1'b1, 8'(i), 8'h00, 8'(i * 17), w);
                    wsum += w;
                end
            end
            begin
                int k;
                k = 0;
                @(negedge CLK);
                while (!bif.mem_run && k < 8) begin
                    @(negedge CLK);
                    k++;
                end
                check("fifo_first_run", bif.mem_run, 1);
                for (int j = 1; j <= 6; j++) begin
                    @(negedge CLK);
                    check("fifo_run_cadence", bif.mem_run, (j % 2 == 0) ? 1 : 0);
                end
            end
        join
        check("fifo_ready_stalls", wsum, 1);
        repeat (6) @(negedge CLK);
`endif

        issue(1'b0, 8'h10, 8'h00, 8'h00, w);
`ifdef MBM_REQ_FIFO_EN
        @(posedge CLK);
        #1;
`endif
        check("abort_in_access", bif.mem_run, 1);
        check("abort_bus_driven", uniBus, 8'h00);
        #2 RST = 1'b0;
        #1;
        check("abort_mem_run", bif.mem_run, 0);
        check("abort_bus_released", uniBus, PROBE);
        check("abort_rsp_valid", bif.rsp_valid, 0);
        check("abort_req_ready", bif.req_ready, 1);
        check("abort_mem_rw", bif.mem_rw, 1);
        sb.delete();
        wq.delete();
        exp_last = 8'h00;
        @(negedge CLK);
        #1;
        check("abort_rsp_rdata", bif.rsp_rdata, 8'h00);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        issue(1'b1, 8'h10, 8'h00, 8'hA5, w);

        repeat (6) @(negedge CLK);
        check("sb_drained", sb.size(), 0);
        check("wq_drained", wq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
